// File: rtl/mul_long_unit_if.sv
// Request/response bundle for mul_long_unit.
// MUL_LONG_ACCUMULATE_EN adds the Accumulate/AccIn request fields.
interface mul_long_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic               Signed;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
`ifdef MUL_LONG_ACCUMULATE_EN
  logic               Accumulate;
  logic [2*WIDTH-1:0] AccIn;
`endif
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   ResultLo;
  logic [WIDTH-1:0]   ResultHi;
  logic [1:0]         Flags;

`ifdef MUL_LONG_ACCUMULATE_EN
  modport master (output start, Signed, a, b, Accumulate, AccIn,
                  input  busy, done, ResultLo, ResultHi, Flags);
  modport slave  (input  start, Signed, a, b, Accumulate, AccIn,
                  output busy, done, ResultLo, ResultHi, Flags);
`else
  modport master (output start, Signed, a, b,
                  input  busy, done, ResultLo, ResultHi, Flags);
  modport slave  (input  start, Signed, a, b,
                  output busy, done, ResultLo, ResultHi, Flags);
`endif
endinterface

// File: rtl/mul_long_unit.sv
// Iterative radix-2 signed/unsigned WIDTH x WIDTH -> 2*WIDTH multiplier.
// Optional accumulate-on-result enabled by macro MUL_LONG_ACCUMULATE_EN.
module mul_long_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  mul_long_unit_if.slave bus
);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic [WIDTH-1:0] mag_a;
  logic [PW-1:0]    prod;
  logic             neg;
`ifdef MUL_LONG_ACCUMULATE_EN
  logic             acc_en;
  logic [PW-1:0]    acc_val;
`endif

  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;
  logic             neg_in;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   step_sum;
  logic [PW-1:0]    prod_signed;
  logic [PW-1:0]    result;

  // Operand magnitudes; the most-negative value maps to its unsigned magnitude.
  always_comb begin
    mag_a_in = bus.a;
    mag_b_in = bus.b;
    if (bus.Signed && bus.a[WIDTH-1]) mag_a_in = ~bus.a + WIDTH'(1);
    if (bus.Signed && bus.b[WIDTH-1]) mag_b_in = ~bus.b + WIDTH'(1);
    neg_in = bus.Signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
  end

  // One shift-add step: the upper half gains the multiplicand when the LSB is set.
  always_comb begin
    addend   = prod[0] ? mag_a : '0;
    step_sum = {1'b0, prod[PW-1:WIDTH]} + {1'b0, addend};
  end

  always_comb begin
    prod_signed = neg ? (~prod + PW'(1)) : prod;
`ifdef MUL_LONG_ACCUMULATE_EN
    result = acc_en ? (prod_signed + acc_val) : prod_signed;
`else
    result = prod_signed;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      last         <= 1'b0;
      mag_a        <= '0;
      prod         <= '0;
      neg          <= 1'b0;
`ifdef MUL_LONG_ACCUMULATE_EN
      acc_en       <= 1'b0;
      acc_val      <= '0;
`endif
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.ResultLo <= '0;
      bus.ResultHi <= '0;
      bus.Flags    <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            mag_a    <= mag_a_in;
            prod     <= {WIDTH'(0), mag_b_in};
            neg      <= neg_in;
`ifdef MUL_LONG_ACCUMULATE_EN
            acc_en   <= bus.Accumulate;
            acc_val  <= bus.AccIn;
`endif
            cnt      <= CNT_W'(WIDTH - 1);
            last     <= 1'b0;
            state    <= RUN;
            bus.busy <= 1'b1;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        RUN: begin
          // WIDTH step edges, then one edge to sign-correct and publish.
          if (!last) begin
            prod <= {step_sum, prod[WIDTH-1:1]};
            if (cnt == '0) last <= 1'b1;
            else           cnt  <= cnt - CNT_W'(1);
          end else begin
            last         <= 1'b0;
            state        <= DONE;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            bus.ResultLo <= result[WIDTH-1:0];
            bus.ResultHi <= result[PW-1:WIDTH];
            bus.Flags    <= {result[PW-1], result == '0};
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
